// File: rtl/sort_engine_8.sv
// In-place bubble sort of DEPTH bytes. It loads, then does one external compare per clock, then unloads.
// Load and unload each take one beat per clock. in_ready is low outside LOAD, and out_ready low stalls the unload.
module sort_engine_8 #(
    parameter int DEPTH  = 8,
    parameter bit ASCEND = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] cmp_a,
    output logic [7:0] cmp_b,
    input  logic       cmp_less,
    input  logic       cmp_equal,
    input  logic       cmp_greater,
    output logic       busy,
    output logic       cmp_err
);

    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_CMP = IW'(DEPTH - 2);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_UNLOAD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wr_q, wr_d, rd_q, rd_d, idx_q, idx_d, pass_q, pass_d;
    logic            swapped_q, swapped_d;
    logic            cmp_err_q, cmp_err_d;
    logic [7:0]      mem_q [DEPTH];

    logic [IW-1:0]   sel_a, sel_b;
    logic            in_ack, out_ack, onehot, do_swap, pass_end;

    // Outside SORT the comparator sees entries 0/1 so its inputs are never stale indices.
    assign sel_a     = (state_q == S_SORT) ? idx_q : '0;
    assign sel_b     = sel_a + IW'(1);
    assign cmp_a     = mem_q[sel_a];
    assign cmp_b     = mem_q[sel_b];

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_UNLOAD);
    assign busy      = (state_q == S_SORT);
    assign out_data  = mem_q[rd_q];
    assign cmp_err   = cmp_err_q;

    assign in_ack    = in_valid && in_ready;
    assign out_ack   = out_valid && out_ready;
    assign onehot    = (cmp_less && !cmp_equal && !cmp_greater) ||
                       (!cmp_less && cmp_equal && !cmp_greater) ||
                       (!cmp_less && !cmp_equal && cmp_greater);
    // Equal keys never swap, keeping the sort stable; a malformed response never swaps either.
    assign do_swap   = onehot && (ASCEND ? cmp_greater : cmp_less);
    assign pass_end  = (idx_q == LAST_CMP - pass_q);

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        cmp_err_d = cmp_err_q;
        case (state_q)
            S_LOAD: begin
                if (in_ack) begin
                    wr_d = wr_q + IW'(1);
                    if (wr_q == LAST_IDX) begin
                        state_d   = S_SORT;
                        wr_d      = '0;
                        idx_d     = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                    end
                end
            end
            S_SORT: begin
                if (!onehot) cmp_err_d = 1'b1;
                if (pass_end) begin
                    // A pass without any swap proves the array sorted.
                    if (!(swapped_q || do_swap) || pass_q == LAST_CMP) begin
                        state_d = S_UNLOAD;
                        rd_d    = '0;
                    end else begin
                        pass_d    = pass_q + IW'(1);
                        idx_d     = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    idx_d     = idx_q + IW'(1);
                    swapped_d = swapped_q || do_swap;
                end
            end
            S_UNLOAD: begin
                if (out_ack) begin
                    rd_d = rd_q + IW'(1);
                    if (rd_q == LAST_IDX) begin
                        state_d = S_LOAD;
                        rd_d    = '0;
                        wr_d    = '0;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            wr_q      <= '0;
            rd_q      <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            cmp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            cmp_err_q <= cmp_err_d;
        end
    end

    // Storage is deliberately not reset; it is only read after a full batch has been written.
    always_ff @(posedge clk) begin
        if (in_ack) begin
            mem_q[wr_q] <= in_data;
        end else if (state_q == S_SORT && do_swap) begin
            mem_q[sel_a] <= cmp_b;
            mem_q[sel_b] <= cmp_a;
        end
    end

endmodule
